argmax_sequencer: RTL and testbench
===================================

Name: argmax_sequencer

Overview:
- Controller that drives one auto_comparator instance to find the arg-max over N signed 16-bit neuron outputs held in an output buffer.
- On start it clears the comparator, reads the buffer two words per pair and pulses the comparator's trig once per pair.
- On completion it latches the winning 1-based index and value and pulses done.
- Sits between the NPU output buffer read port and the comparator, under control of the top-level sequencer.

Parameters:
DATA_W, 16, width of buffer words and comparator operands (signed).
ADDR_W, 8, buffer address width; also the width of n_outputs and result_index.

Ports:
CLKEXT  in  1  system clock, rising edge.
RST  in  1  asynchronous active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
abort  in  1  soft cancel; return to IDLE without done.
n_outputs  in  ADDR_W  number of values N, 0..255; latched on start.
base_addr  in  ADDR_W  buffer address of the first value; latched on start.
rd_en  out  1  buffer read strobe.
rd_addr  out  ADDR_W  buffer read address.
rd_data  in  DATA_W  buffer read data, valid one cycle after rd_en.
EN_COMP  out  1  comparator enable.
RST_COMP  out  1  comparator synchronous clear.
trig  out  1  comparator compare strobe.
in1  out  DATA_W  comparator operand A (registered).
in2  out  DATA_W  comparator operand B (registered).
index  in  ADDR_W  comparator running 1-based arg-max.
largest  in  DATA_W  comparator running maximum.
busy  out  1  high in every state except IDLE and DONE.
done  out  1  one-cycle completion pulse.
err  out  1  high with done when N=0.
result_index  out  ADDR_W  final arg-max, 1-based; 0 means no value beat 16'sh8000.
result_value  out  DATA_W  final maximum.

Behaviour:
- Reset values:
  - All outputs 0, except in1, in2 and result_value, which reset to 16'sh8000.
  - State resets to IDLE.
  - Reset is asynchronous and may occur mid-operation; no done is issued and the comparator's contents are left stale.
- FSM states: IDLE, CLEAR, FETCH_A, FETCH_B, LATCH, FIRE, WAIT, DONE.
- IDLE:
  - start=1 and N>0: latch N and base_addr, set k=0, go to CLEAR.
  - start=1 and N=0: go to DONE with err=1, result_index=0, result_value=16'sh8000; no buffer reads and no comparator activity.
- CLEAR: RST_COMP=1 and EN_COMP=1 for exactly one cycle, then FETCH_A.
- Per pair (FETCH_A → FETCH_B → LATCH → FIRE, 4 cycles):
  - FETCH_A: rd_en=1, rd_addr=base+k.
  - FETCH_B: latch rd_data into in1. If k+1<N, issue rd_en=1, rd_addr=base+k+1; otherwise rd_en=0.
  - LATCH: load in2 with rd_data, or with 16'sh8000 pad when no second read was issued (odd N).
  - FIRE: trig=1 with in1/in2 stable; k += 2. If k<N go to FETCH_A, else go to WAIT.
- WAIT: one cycle so the comparator's index/largest settle; go to DONE.
- DONE:
  - result_index and result_value are captured from index/largest on the edge entering DONE.
  - done=1 for one cycle, then IDLE.
  - Results hold until the next completed run.
- EN_COMP=1 from CLEAR through WAIT inclusive; trig is high only in FIRE.
- Latency with P=ceil(N/2): done rises 4P+2 clock edges after the edge that accepts start. N=0 gives done on the next edge.
- Address arithmetic wraps modulo 2^ADDR_W; k is ADDR_W+1 bits so N=255 terminates.
- start while busy or in DONE is ignored.
- abort while busy: IDLE on the next edge; no done and no result update. Abort has priority over FSM advance.
- Ties: the comparator keeps the earlier index on ties. The pad value never wins.

Test Plan:
- N=4, base=0x10, buffer {5, -3, 9, 9} → done 10 edges after start, result_index=3, result_value=9, exactly 2 trig pulses, reads at 0x10..0x13.
- N=3, buffer {-7, -2, -9} → result_index=2, value=-2; 2 trig pulses; only 3 rd_en pulses; in2 = 16'sh8000 on the second FIRE.
- N=0 → done and err high one edge after start, result_index=0, result_value=16'sh8000, rd_en/trig never asserted.
- base=0xFE, N=4 → rd_addr sequence 0xFE, 0xFF, 0x00, 0x01; correct arg-max returned.
- abort asserted during the second FETCH_B of N=6 → IDLE next edge, no done, previous results unchanged; a new start then completes normally with RST_COMP pulsed.
- RST asserted asynchronously mid-LATCH → all outputs at reset values immediately; second start while busy ignored (trig count unchanged).

Source files
------------

// File: rtl/argmax_sequencer.sv
// -----------------------------------------------------------------------------
// argmax_sequencer
//   Drives one auto_comparator to find the arg-max over N signed buffer words.
//   On start the comparator is cleared, the buffer is read two words per pair,
//   and the comparator's trig is pulsed once per pair. On completion the
//   1-based winning index and its value are latched and done pulses.
//
// Ports
//   CLKEXT, RST            clock (rising edge), asynchronous active-high reset
//   start, abort           run request (IDLE only) / soft cancel while busy
//   n_outputs, base_addr   word count N and first buffer address (latched)
//   rd_en, rd_addr         buffer read strobe/address; rd_data one cycle later
//   EN_COMP, RST_COMP      comparator enable / synchronous clear
//   trig, in1, in2         comparator compare strobe and registered operands
//   index, largest         comparator running arg-max and maximum
//   busy, done, err        status; err accompanies done when N=0
//   result_index/_value    final arg-max (1-based, 0 = nothing beat 0x8000)
//   state_dbg_o            current FSM state encoding
//
// Handshake: start is a single-cycle request honoured only in IDLE; done is a
// single-cycle pulse and result_* are stable from done until the next done.
// -----------------------------------------------------------------------------
module argmax_sequencer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              CLKEXT,
   input  logic              RST,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] n_outputs,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              EN_COMP,
   output logic              RST_COMP,
   output logic              trig,
   output logic [DATA_W-1:0] in1,
   output logic [DATA_W-1:0] in2,
   input  logic [ADDR_W-1:0] index,
   input  logic [DATA_W-1:0] largest,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] result_index,
   output logic [DATA_W-1:0] result_value,
   output logic [2:0]        state_dbg_o
);

   // Most negative value: used as the odd-N pad and the "no result" value.
   localparam logic [DATA_W-1:0] PAD = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_FETCH_A = 3'd2,
      S_FETCH_B = 3'd3,
      S_LATCH   = 3'd4,
      S_FIRE    = 3'd5,
      S_WAIT    = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   n_q;
   logic [ADDR_W-1:0]   base_q;
   // One bit wider than N so that k can reach N+1 when N=255.
   logic [ADDR_W:0]     k_q;
   logic                second_q;     // second word of the pair was read
   logic                rd_en_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic                en_comp_q;
   logic                rst_comp_q;
   logic                trig_q;
   logic [DATA_W-1:0]   in1_q;
   logic [DATA_W-1:0]   in2_q;
   logic                done_q;
   logic                err_q;
   logic [ADDR_W-1:0]   res_idx_q;
   logic [DATA_W-1:0]   res_val_q;

   logic [ADDR_W:0]     k_plus1_d;
   logic [ADDR_W:0]     k_plus2_d;
   logic [ADDR_W-1:0]   addr_k1_d;
   logic [ADDR_W-1:0]   addr_k2_d;
   logic                busy_d;

   always_comb begin
      k_plus1_d = k_q + {{ADDR_W{1'b0}}, 1'b1};
      k_plus2_d = k_q + {{(ADDR_W-1){1'b0}}, 2'd2};
      // Buffer addresses wrap modulo 2^ADDR_W.
      addr_k1_d = base_q + k_plus1_d[ADDR_W-1:0];
      addr_k2_d = base_q + k_plus2_d[ADDR_W-1:0];
      busy_d    = (state_q != S_IDLE) && (state_q != S_DONE);
   end

   always_ff @(posedge CLKEXT or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         base_q     <= '0;
         k_q        <= '0;
         second_q   <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         en_comp_q  <= 1'b0;
         rst_comp_q <= 1'b0;
         trig_q     <= 1'b0;
         in1_q      <= PAD;
         in2_q      <= PAD;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         res_idx_q  <= '0;
         res_val_q  <= PAD;
      end else begin
         // Single-cycle strobes fall back to 0 unless a state re-asserts them.
         rd_en_q    <= 1'b0;
         rst_comp_q <= 1'b0;
         trig_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         if (abort && busy_d) begin
            state_q   <= S_IDLE;
            en_comp_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     if (n_outputs == '0) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        res_idx_q <= '0;
                        res_val_q <= PAD;
                     end else begin
                        state_q    <= S_CLEAR;
                        n_q        <= n_outputs;
                        base_q     <= base_addr;
                        k_q        <= '0;
                        en_comp_q  <= 1'b1;
                        rst_comp_q <= 1'b1;
                     end
                  end
               end
               S_CLEAR: begin
                  state_q   <= S_FETCH_A;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= base_q + k_q[ADDR_W-1:0];
               end
               S_FETCH_A: begin
                  // Outputs registered here are the ones visible in FETCH_B.
                  state_q  <= S_FETCH_B;
                  second_q <= (k_plus1_d < {1'b0, n_q});
                  if (k_plus1_d < {1'b0, n_q}) begin
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= addr_k1_d;
                  end
               end
               S_FETCH_B: begin
                  state_q <= S_LATCH;
                  in1_q   <= rd_data;
               end
               S_LATCH: begin
                  state_q <= S_FIRE;
                  in2_q   <= second_q ? rd_data : PAD;
                  trig_q  <= 1'b1;
               end
               S_FIRE: begin
                  k_q <= k_plus2_d;
                  if (k_plus2_d < {1'b0, n_q}) begin
                     state_q   <= S_FETCH_A;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= addr_k2_d;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  state_q   <= S_DONE;
                  en_comp_q <= 1'b0;
                  done_q    <= 1'b1;
                  res_idx_q <= index;
                  res_val_q <= largest;
               end
               S_DONE: begin
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign rd_en        = rd_en_q;
   assign rd_addr      = rd_addr_q;
   assign EN_COMP      = en_comp_q;
   assign RST_COMP     = rst_comp_q;
   assign trig         = trig_q;
   assign in1          = in1_q;
   assign in2          = in2_q;
   assign busy         = busy_d;
   assign done         = done_q;
   assign err          = err_q;
   assign result_index = res_idx_q;
   assign result_value = res_val_q;
   assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_argmax_sequencer.sv
module tb_argmax_sequencer;

  localparam int W = 65;  // {err,idx[8],val[16],lat[16],trig[8],rd[8],rc[8]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, abort;
  logic [7:0]  n_outputs, base_addr;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        en_comp, rst_comp, trig;
  logic [15:0] in1, in2;
  logic [7:0]  cmp_idx;
  logic [15:0] cmp_large;
  logic        busy, done, err;
  logic [7:0]  result_index;
  logic [15:0] result_value;
  logic [2:0]  state_dbg;

  argmax_sequencer dut (
    .CLKEXT(clk), .RST(rst), .start(start), .abort(abort),
    .n_outputs(n_outputs), .base_addr(base_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .EN_COMP(en_comp), .RST_COMP(rst_comp), .trig(trig),
    .in1(in1), .in2(in2), .index(cmp_idx), .largest(cmp_large),
    .busy(busy), .done(done), .err(err),
    .result_index(result_index), .result_value(result_value),
    .state_dbg_o(state_dbg)
  );

  // ---------------- buffer and comparator models ----------------
  logic [15:0] mem [0:255];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  logic [8:0] cmp_cnt;
  always @(posedge clk) begin : cmp_model
    logic signed [15:0] nl;
    logic [7:0]         ni;
    if (en_comp && rst_comp) begin
      cmp_idx   <= 8'd0;
      cmp_large <= 16'h8000;
      cmp_cnt   <= 9'd0;
    end else if (en_comp && trig) begin
      nl = cmp_large;
      ni = cmp_idx;
      if ($signed(in1) > nl) begin nl = in1; ni = 8'(cmp_cnt + 9'd1); end
      if ($signed(in2) > nl) begin nl = in2; ni = 8'(cmp_cnt + 9'd2); end
      cmp_large <= nl;
      cmp_idx   <= ni;
      cmp_cnt   <= cmp_cnt + 9'd2;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_addr_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, cyc_raise = 0;
  int trig_total = 0, rd_total = 0, rc_total = 0, done_total = 0;
  int trig0 = 0, rd0 = 0, rc0 = 0;
  logic [15:0] last_in2 = 16'h0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  // Monitor: samples on the falling edge, pops expectations as outputs appear.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [7:0]   ea;
    cyc++;
    if (!rst) begin
      if (trig) begin trig_total++; last_in2 = in2; end
      if (rst_comp && en_comp) rc_total++;
      if (rd_en) begin
        rd_total++;
        if (exp_addr_q.size() == 0) check("unexpected_read", 32'(rd_addr), 32'hFFFF);
        else begin
          ea = exp_addr_q.pop_front();
          check("rd_addr", 32'(rd_addr), 32'(ea));
        end
      end
      if (done) begin
        done_total++;
        if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("err",          32'(err),               32'(e[64]));
          check("result_index", 32'(result_index),      32'(e[63:56]));
          check("result_value", 32'(result_value),      32'(e[55:40]));
          check("latency",      32'(cyc - cyc_raise - 2), 32'(e[39:24]));
          check("trig_count",   32'(trig_total - trig0), 32'(e[23:16]));
          check("read_count",   32'(rd_total - rd0),     32'(e[15:8]));
          check("clear_count",  32'(rc_total - rc0),     32'(e[7:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input logic [7:0] n, input logic [7:0] base);
    @(posedge clk); #2;
    cyc_raise = cyc; trig0 = trig_total; rd0 = rd_total; rc0 = rc_total;
    start = 1'b1; n_outputs = n; base_addr = base;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic expect_run(input logic [7:0] n, input logic [7:0] base,
                            input logic e_err, input logic [7:0] e_idx,
                            input logic [15:0] e_val, input logic [15:0] e_lat,
                            input logic [7:0] e_trig, input logic [7:0] e_rd,
                            input logic [7:0] e_rc);
    exp_q.push_back({e_err, e_idx, e_val, e_lat, e_trig, e_rd, e_rc});
    for (int i = 0; i < int'(n); i++) exp_addr_q.push_back(8'(base + 8'(i)));
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0) && (t < 1000)) begin @(posedge clk); t++; end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    check("addr_leftover", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic run(input logic [7:0] n, input logic [7:0] base,
                     input logic e_err, input logic [7:0] e_idx,
                     input logic [15:0] e_val, input logic [15:0] e_lat,
                     input logic [7:0] e_trig, input logic [7:0] e_rd);
    expect_run(n, base, e_err, e_idx, e_val, e_lat, e_trig, e_rd, (n == 0) ? 8'd0 : 8'd1);
    issue_start(n, base);
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},    32'(rd_en),        32'd0);
    check({tag, "_rd_addr"},  32'(rd_addr),      32'd0);
    check({tag, "_en_comp"},  32'(en_comp),      32'd0);
    check({tag, "_rst_comp"}, 32'(rst_comp),     32'd0);
    check({tag, "_trig"},     32'(trig),         32'd0);
    check({tag, "_in1"},      32'(in1),          32'h8000);
    check({tag, "_in2"},      32'(in2),          32'h8000);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_done"},     32'(done),         32'd0);
    check({tag, "_err"},      32'(err),          32'd0);
    check({tag, "_res_idx"},  32'(result_index), 32'd0);
    check({tag, "_res_val"},  32'(result_value), 32'h8000);
    check({tag, "_state"},    32'(state_dbg),    32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; abort = 1'b0; n_outputs = 8'd0; base_addr = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (3) @(posedge clk); #2;
    check_reset_outputs("por");
    rst = 1'b0;

    // N=4 with a tie at the maximum: earlier index 3 wins.
    mem[8'h10] = 16'd5; mem[8'h11] = -16'sd3; mem[8'h12] = 16'd9; mem[8'h13] = 16'd9;
    run(8'd4, 8'h10, 1'b0, 8'd3, 16'd9, 16'd10, 8'd2, 8'd4);

    // N=3: odd count, second pair padded.
    mem[8'h20] = -16'sd7; mem[8'h21] = -16'sd2; mem[8'h22] = -16'sd9;
    run(8'd3, 8'h20, 1'b0, 8'd2, 16'hFFFE, 16'd10, 8'd2, 8'd3);
    check("pad_in2", 32'(last_in2), 32'h8000);

    // N=0: immediate done with err.
    run(8'd0, 8'h00, 1'b1, 8'd0, 16'h8000, 16'd0, 8'd0, 8'd0);

    // Address wrap across 0xFF.
    mem[8'hFE] = 16'd1; mem[8'hFF] = 16'd7; mem[8'h00] = -16'sd4; mem[8'h01] = 16'd7;
    run(8'd4, 8'hFE, 1'b0, 8'd2, 16'd7, 16'd10, 8'd2, 8'd4);

    // Abort during the second FETCH_B of N=6.
    mem[8'h30] = 16'd0;   mem[8'h31] = -16'sd1; mem[8'h32] = 16'd100;
    mem[8'h33] = 16'd3;   mem[8'h34] = -16'sd100; mem[8'h35] = 16'd50;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(8'(8'h30 + 8'(i)));
    dn = done_total;
    issue_start(8'd6, 8'h30);
    repeat (6) @(posedge clk); #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    check("abort_busy",     32'(busy),              32'd0);
    check("abort_en_comp",  32'(en_comp),           32'd0);
    check("abort_state",    32'(state_dbg),         32'd0);
    check("abort_trigs",    32'(trig_total - trig0), 32'd1);
    check("abort_reads",    32'(rd_total - rd0),    32'd4);
    repeat (5) @(posedge clk); #2;
    check("abort_no_done",  32'(done_total - dn),   32'd0);
    check("abort_keep_idx", 32'(result_index),      32'd2);
    check("abort_keep_val", 32'(result_value),      32'd7);
    check("abort_addr_q",   32'(exp_addr_q.size()), 32'd0);
    run(8'd6, 8'h30, 1'b0, 8'd3, 16'd100, 16'd14, 8'd3, 8'd6);

    // N=1 holding the pad value: nothing beats it, index 0.
    mem[8'h40] = 16'h8000;
    run(8'd1, 8'h40, 1'b0, 8'd0, 16'h8000, 16'd6, 8'd1, 8'd1);

    // Asynchronous reset in LATCH, then a start issued while busy is ignored.
    mem[8'h50] = 16'hFFFF; mem[8'h51] = 16'hFFFF; mem[8'h52] = 16'hFFFF; mem[8'h53] = 16'hFFFF;
    exp_addr_q.push_back(8'h50); exp_addr_q.push_back(8'h51);
    issue_start(8'd4, 8'h50);
    repeat (3) @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    check("async_addr_q", 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    expect_run(8'd4, 8'h50, 1'b0, 8'd1, 16'hFFFF, 16'd10, 8'd2, 8'd4, 8'd1);
    issue_start(8'd4, 8'h50);
    repeat (4) @(posedge clk); #2;
    start = 1'b1; n_outputs = 8'd1; base_addr = 8'h00;
    @(posedge clk); #2;
    start = 1'b0;
    drain();

    // N=255: counter must run past 255 and stop; winner is the last real word.
    for (int i = 0; i < 255; i++) mem[i] = 16'(i);
    run(8'd255, 8'h00, 1'b0, 8'd255, 16'd254, 16'd514, 8'd128, 8'd255);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
